shiftreg_seq_ctrl: RTL and testbench

Sequencer for the 4-bit load/shift register block (clr, load, data, ena, A, Q, E).
- Accepts a transfer command over a start/ready handshake.
- Drives the register through clear, parallel load and N serial shifts, feeding serial-in bits and capturing serial-out bits.
- Returns the captured serial word and the final register contents with a one-cycle done pulse.
- Sits between a host/test controller and one shift register instance.

---
 rtl/shiftreg_seq_ctrl_if.sv | 27 ++
 rtl/shiftreg_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_shiftreg_seq_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shiftreg_seq_ctrl_if.sv
// Host-side command/result bundle for shiftreg_seq_ctrl.
// master = host/test controller, slave = sequencer.
interface shiftreg_seq_ctrl_if #(
  parameter int W    = 4,
  parameter int CNTW = 3
);
  logic            start;
  logic            ready;
  logic [W-1:0]    data_in;
  logic [W-1:0]    ser_in;
  logic [CNTW-1:0] shift_cnt;
  logic            abort;
  logic            busy;
  logic            done;
  logic [W-1:0]    ser_out;
  logic [W-1:0]    q_out;

  modport master (
    output start, data_in, ser_in, shift_cnt, abort,
    input  ready, busy, done, ser_out, q_out
  );

  modport slave (
    input  start, data_in, ser_in, shift_cnt, abort,
    output ready, busy, done, ser_out, q_out
  );
endinterface

// File: rtl/shiftreg_seq_ctrl.sv
// Sequencer for a 4-bit load/shift register: clear, load,
// N serial shifts with capture, then report results.
module shiftreg_seq_ctrl #(
  parameter int W    = 4,
  parameter int CNTW = 3
) (
  input  logic               clk,
  input  logic               clr_n,
  shiftreg_seq_ctrl_if.slave host,
  output logic               sr_clr,
  output logic               sr_load,
  output logic [W-1:0]       sr_data,
  output logic               sr_ena,
  output logic               sr_A,
  input  logic [W-1:0]       sr_Q,
  input  logic               sr_E
);

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  typedef struct packed {
    logic [W-1:0]    data;
    logic [W-1:0]    ser;
    logic [CNTW-1:0] cnt;
  } cmd_t;

  localparam logic [CNTW-1:0] CMAX = CNTW'(W);

  state_t          state;
  cmd_t            cmd;
  logic [CNTW-1:0] idx;
  logic [W-1:0]    ser_q;
  logic [W-1:0]    q_q;
  logic [CNTW-1:0] cnt_sat;
  logic [W-1:0]    ser_sh;
  logic            last;
  logic            kill;

  assign cnt_sat = (host.shift_cnt > CMAX) ?
                   CMAX : host.shift_cnt;
  assign ser_sh  = cmd.ser >> idx;
  assign last    = (idx == cmd.cnt - CNTW'(1));
  assign kill    = host.abort &&
                   (state == LOAD ||
                    state == SHIFT ||
                    state == DONE);

  assign host.ser_out = ser_q;
  assign host.q_out   = q_q;

  always_comb begin
    sr_clr     = 1'b0;
    sr_load    = 1'b0;
    sr_data    = '0;
    sr_ena     = 1'b0;
    sr_A       = 1'b0;
    host.ready = 1'b0;
    host.busy  = 1'b0;
    host.done  = 1'b0;
    unique case (state)
      CLEAR: sr_clr = 1'b1;
      IDLE:  host.ready = 1'b1;
      LOAD: begin
        sr_load   = 1'b1;
        sr_data   = cmd.data;
        host.busy = 1'b1;
      end
      SHIFT: begin
        sr_ena    = 1'b1;
        sr_A      = ser_sh[0];
        host.busy = 1'b1;
      end
      DONE: begin
        host.busy = 1'b1;
        host.done = 1'b1;
      end
      default: ;
    endcase
  end

  // Abort leaves ser_out/q_out untouched; only clr_n wipes them.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= CLEAR;
      cmd   <= '0;
      idx   <= '0;
      ser_q <= '0;
      q_q   <= '0;
    end else if (kill) begin
      state <= CLEAR;
    end else begin
      unique case (state)
        CLEAR: state <= IDLE;
        IDLE: begin
          if (host.start) begin
            cmd   <= '{data: host.data_in,
                       ser:  host.ser_in,
                       cnt:  cnt_sat};
            idx   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          ser_q <= '0;
          state <= (cmd.cnt == '0) ? DONE : SHIFT;
        end
        SHIFT: begin
          ser_q <= ser_q | (W'(sr_E) << idx);
          idx   <= idx + CNTW'(1);
          if (last) state <= DONE;
        end
        DONE: begin
          q_q   <= sr_Q;
          state <= IDLE;
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// Randomized bench for shiftreg_seq_ctrl with a right-shift
// register model and an arithmetic reference for the results.
module tb_shiftreg_seq_ctrl;
  localparam int W    = 4;
  localparam int CNTW = 3;

  logic         clk   = 1'b0;
  logic         clr_n = 1'b0;
  logic         sr_clr, sr_load, sr_ena, sr_A, sr_E;
  logic [W-1:0] sr_data, sr_Q;
  logic [W-1:0] rq = '0;

  int   compared   = 0;
  int   mismatched = 0;
  logic mon_en     = 1'b0;
  logic prev_done  = 1'b0;
  logic [W-1:0] q_last = '0;

  shiftreg_seq_ctrl_if #(.W(W), .CNTW(CNTW)) hif();

  shiftreg_seq_ctrl #(.W(W), .CNTW(CNTW)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .host    (hif),
    .sr_clr  (sr_clr),
    .sr_load (sr_load),
    .sr_data (sr_data),
    .sr_ena  (sr_ena),
    .sr_A    (sr_A),
    .sr_Q    (sr_Q),
    .sr_E    (sr_E)
  );

  always #5 clk = ~clk;

  // The controlled register: right shift, clr/load override ena.
  always @(posedge clk) begin
    if (sr_clr)       rq <= '0;
    else if (sr_load) rq <= sr_data;
    else if (sr_ena)  rq <= {sr_A, rq[W-1:1]};
  end
  assign sr_Q = rq;
  assign sr_E = rq[0];

  always @(negedge clk) begin
    if (mon_en) begin
      compared++;
      if ((sr_load && sr_ena) ||
          !$onehot({sr_clr, hif.ready, hif.busy}) ||
          (hif.done && !hif.busy) ||
          (hif.done && prev_done)) begin
        mismatched++;
        $display("FAIL invariant t=%0t clr=%b ld=%b en=%b rdy=%b busy=%b done=%b prev_done=%b",
                 $time, sr_clr, sr_load, sr_ena, hif.ready,
                 hif.busy, hif.done, prev_done);
      end
      prev_done = hif.done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  function automatic int nsh(input logic [2:0] c);
    return (int'(c) > W) ? W : int'(c);
  endfunction

  function automatic logic [W-1:0] mask_lo(input logic [W-1:0] v,
                                           input int n);
    int m;
    m = (1 << n) - 1;
    return W'(int'(v) & m);
  endfunction

  // After n shifts: bits of d below n have left via E, s fills the top.
  function automatic logic [W-1:0] exp_q(input logic [W-1:0] d,
                                         input logic [W-1:0] s,
                                         input int n);
    int v;
    v = (int'(d) >> n) | (int'(s) << (W - n));
    return W'(v & ((1 << W) - 1));
  endfunction

  task automatic issue(input logic [W-1:0] d, input logic [W-1:0] s,
                       input logic [2:0] c, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (hif.ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      hif.data_in   = d;
      hif.ser_in    = s;
      hif.shift_cnt = c;
      hif.start     = 1'b1;
      @(posedge clk);
      #1;
      hif.start = 1'b0;
    end
  endtask

  task automatic observe(output int kd, output int ne, output int nl,
                         output logic [W-1:0] ab);
    kd = 0;
    ne = 0;
    nl = 0;
    ab = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (sr_load) nl++;
      if (sr_ena) begin
        if (ne < W) ab[ne] = sr_A;
        ne++;
      end
      if (hif.done) begin
        kd = k;
        break;
      end
    end
  endtask

  task automatic run(input logic [W-1:0] d, input logic [W-1:0] s,
                     input logic [2:0] c, output int kd,
                     output int ne, output int nl,
                     output logic [W-1:0] ab, output logic [W-1:0] so,
                     output logic [W-1:0] qo, output logic rdy);
    logic ok;
    issue(d, s, c, ok);
    kd = 0; ne = 0; nl = 0; ab = '0;
    so = 'x; qo = 'x; rdy = 1'b0;
    if (ok) begin
      observe(kd, ne, nl, ab);
      @(negedge clk);
      so  = hif.ser_out;
      qo  = hif.q_out;
      rdy = hif.ready;
    end
  endtask

  task automatic test_reset;
    clr_n = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    compared++;
    if ({sr_clr, hif.ready, hif.busy, hif.done} !== 4'b1000) begin
      mismatched++;
      $display("FAIL reset_hold: clr/rdy/busy/done=%b want 1000",
               {sr_clr, hif.ready, hif.busy, hif.done});
    end
    @(posedge clk);
    #1 clr_n = 1'b1;
    @(negedge clk);
    compared++;
    if ({sr_clr, hif.ready} !== 2'b10) begin
      mismatched++;
      $display("FAIL reset_clear_cycle: clr/rdy=%b want 10",
               {sr_clr, hif.ready});
    end
    @(negedge clk);
    compared++;
    if ({sr_clr, hif.ready, hif.busy, hif.ser_out, hif.q_out}
        !== {3'b010, 8'h00}) begin
      mismatched++;
      $display("FAIL reset_idle: clr/rdy/busy=%b ser=%b q=%b want 010 0000 0000",
               {sr_clr, hif.ready, hif.busy}, hif.ser_out, hif.q_out);
    end
    q_last = '0;
  endtask

  task automatic test_directed;
    int kd, ne, nl;
    logic [W-1:0] ab, so, qo;
    logic rdy;
    run(4'b1101, 4'b1010, 3'd4, kd, ne, nl, ab, so, qo, rdy);
    compared++;
    if (kd !== 6 || nl !== 1 || ne !== 4) begin
      mismatched++;
      $display("FAIL dir_timing: done_k=%0d loads=%0d enas=%0d want 6 1 4",
               kd, nl, ne);
    end
    compared++;
    if (ab !== 4'b1010) begin
      mismatched++;
      $display("FAIL dir_A_seq: got %b want 1010", ab);
    end
    compared++;
    if (so !== 4'b1101 || qo !== 4'b1010 || rdy !== 1'b1) begin
      mismatched++;
      $display("FAIL dir_result: ser=%b q=%b rdy=%b want 1101 1010 1",
               so, qo, rdy);
    end
    q_last = 4'b1010;
  endtask

  task automatic test_zero_cnt;
    int kd, ne, nl;
    logic [W-1:0] ab, so, qo;
    logic rdy;
    run(4'b0110, 4'($urandom), 3'd0, kd, ne, nl, ab, so, qo, rdy);
    compared++;
    if (kd !== 2 || ne !== 0 || nl !== 1) begin
      mismatched++;
      $display("FAIL zero_timing: done_k=%0d enas=%0d loads=%0d want 2 0 1",
               kd, ne, nl);
    end
    compared++;
    if (so !== 4'b0000 || qo !== 4'b0110) begin
      mismatched++;
      $display("FAIL zero_result: ser=%b q=%b want 0000 0110", so, qo);
    end
    q_last = 4'b0110;
  endtask

  task automatic test_saturate;
    int kd, ne, nl;
    logic [W-1:0] d, s, ab, so, qo;
    logic rdy;
    d = 4'($urandom);
    s = 4'($urandom);
    run(d, s, 3'd7, kd, ne, nl, ab, so, qo, rdy);
    compared++;
    if (ne !== W || kd !== W + 2) begin
      mismatched++;
      $display("FAIL sat_count: enas=%0d done_k=%0d want %0d %0d",
               ne, kd, W, W + 2);
    end
    compared++;
    if (so !== d || qo !== s) begin
      mismatched++;
      $display("FAIL sat_result: ser=%b q=%b want %b %b", so, qo, d, s);
    end
    q_last = s;
  endtask

  task automatic test_random;
    int kd, ne, nl, n;
    logic [W-1:0] d, s, ab, so, qo;
    logic [2:0] c;
    logic rdy;
    for (int it = 0; it < 25; it++) begin
      d = 4'($urandom);
      s = 4'($urandom);
      c = 3'($urandom_range(0, 7));
      n = nsh(c);
      run(d, s, c, kd, ne, nl, ab, so, qo, rdy);
      compared++;
      if (kd !== n + 2 || ne !== n || nl !== 1 ||
          ab !== mask_lo(s, n)) begin
        mismatched++;
        $display("FAIL rand_seq[%0d]: c=%0d done_k=%0d enas=%0d loads=%0d A=%b want %0d %0d 1 %b",
                 it, c, kd, ne, nl, ab, n + 2, n, mask_lo(s, n));
      end
      compared++;
      if (so !== mask_lo(d, n) || qo !== exp_q(d, s, n)) begin
        mismatched++;
        $display("FAIL rand_result[%0d]: d=%b s=%b c=%0d ser=%b q=%b want %b %b",
                 it, d, s, c, so, qo, mask_lo(d, n), exp_q(d, s, n));
      end
      q_last = exp_q(d, s, n);
    end
  endtask

  task automatic test_back_to_back;
    int kd1, ne1, nl1, kd2, ne2, nl2, n1, n2;
    logic [W-1:0] d1, s1, d2, s2, ab1, ab2;
    logic [2:0] c1, c2;
    d1 = 4'($urandom); s1 = 4'($urandom);
    c1 = 3'($urandom_range(1, 7));
    d2 = 4'($urandom); s2 = 4'($urandom);
    c2 = 3'($urandom_range(0, 7));
    n1 = nsh(c1);
    n2 = nsh(c2);
    for (int i = 0; i < 20 && !hif.ready; i++) @(negedge clk);
    hif.data_in   = d1;
    hif.ser_in    = s1;
    hif.shift_cnt = c1;
    hif.start     = 1'b1;
    @(posedge clk);
    #1;
    observe(kd1, ne1, nl1, ab1);
    hif.data_in   = d2;
    hif.ser_in    = s2;
    hif.shift_cnt = c2;
    @(negedge clk);
    compared++;
    if (kd1 !== n1 + 2 || hif.ready !== 1'b1 || hif.done !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_first: done_k=%0d rdy=%b done=%b want %0d 1 0",
               kd1, hif.ready, hif.done, n1 + 2);
    end
    compared++;
    if (hif.ser_out !== mask_lo(d1, n1) ||
        hif.q_out !== exp_q(d1, s1, n1)) begin
      mismatched++;
      $display("FAIL b2b_first_result: ser=%b q=%b want %b %b",
               hif.ser_out, hif.q_out, mask_lo(d1, n1),
               exp_q(d1, s1, n1));
    end
    observe(kd2, ne2, nl2, ab2);
    hif.start = 1'b0;
    compared++;
    if (kd2 !== n2 + 2 || ne2 !== n2 || nl2 !== 1) begin
      mismatched++;
      $display("FAIL b2b_second: done_k=%0d enas=%0d loads=%0d want %0d %0d 1",
               kd2, ne2, nl2, n2 + 2, n2);
    end
    @(negedge clk);
    compared++;
    if (hif.ser_out !== mask_lo(d2, n2) ||
        hif.q_out !== exp_q(d2, s2, n2)) begin
      mismatched++;
      $display("FAIL b2b_second_result: ser=%b q=%b want %b %b",
               hif.ser_out, hif.q_out, mask_lo(d2, n2),
               exp_q(d2, s2, n2));
    end
    q_last = exp_q(d2, s2, n2);
    repeat (3) @(negedge clk);
    compared++;
    if (hif.ready !== 1'b1 || sr_load !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_no_queue: rdy=%b load=%b want 1 0",
               hif.ready, sr_load);
    end
  endtask

  task automatic test_abort;
    logic [W-1:0] d;
    logic ok;
    d = 4'($urandom);
    issue(d, 4'($urandom), 3'd4, ok);
    repeat (3) @(negedge clk);
    compared++;
    if (ok !== 1'b1 || sr_ena !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_setup: accepted=%b ena=%b want 1 1", ok, sr_ena);
    end
    hif.abort = 1'b1;
    @(negedge clk);
    hif.abort = 1'b0;
    compared++;
    if (sr_clr !== 1'b1 || hif.done !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_clear: clr=%b done=%b want 1 0",
               sr_clr, hif.done);
    end
    @(negedge clk);
    compared++;
    if (hif.ready !== 1'b1 || hif.done !== 1'b0 ||
        hif.ser_out !== (d & 4'b0001) || hif.q_out !== q_last) begin
      mismatched++;
      $display("FAIL abort_recover: rdy=%b done=%b ser=%b q=%b want 1 0 %b %b",
               hif.ready, hif.done, hif.ser_out, hif.q_out,
               d & 4'b0001, q_last);
    end
    hif.abort = 1'b1;
    @(negedge clk);
    hif.abort = 1'b0;
    compared++;
    if (hif.ready !== 1'b1 || sr_clr !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_idle: rdy=%b clr=%b want 1 0",
               hif.ready, sr_clr);
    end
  endtask

  task automatic test_reset_mid;
    logic ok;
    issue(4'($urandom), 4'($urandom), 3'd4, ok);
    repeat (3) @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    compared++;
    if ({sr_clr, hif.ready, hif.busy, hif.done} !== 4'b1000 ||
        hif.ser_out !== 4'b0000 || hif.q_out !== 4'b0000 || !ok) begin
      mismatched++;
      $display("FAIL rstmid_clear: clr/rdy/busy/done=%b ser=%b q=%b acc=%b want 1000 0000 0000 1",
               {sr_clr, hif.ready, hif.busy, hif.done},
               hif.ser_out, hif.q_out, ok);
    end
    clr_n = 1'b1;
    @(negedge clk);
    compared++;
    if (hif.ready !== 1'b1 || hif.done !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_recover: rdy=%b done=%b want 1 0",
               hif.ready, hif.done);
    end
    q_last = '0;
  endtask

  initial begin
    hif.start     = 1'b0;
    hif.data_in   = '0;
    hif.ser_in    = '0;
    hif.shift_cnt = '0;
    hif.abort     = 1'b0;
    test_reset();
    test_directed();
    test_zero_cnt();
    test_saturate();
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_directed();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
